// File: rtl/tunnel_map.sv
// tunnel_map: one-bit-per-cell dug map with player digging, clear/seed sequencing and per-pixel tunnel lookup.
// Define TUNNEL_COUNT_EN to maintain dugCount; otherwise dugCount is tied to zero.
module tunnel_map #(
  parameter logic [10:0] board_position_X = 11'd32,
  parameter logic [10:0] board_position_Y = 11'd160,
  parameter int COLS = 15,
  parameter int ROWS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               clearMap,
  input  logic               player_awake,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  output logic               tunnelDR,
  output logic         [7:0] dugCount,
  output logic               busy
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [12:0] XSPAN = 13'(COLS * 32);
  localparam logic [12:0] YSPAN = 13'(ROWS * 32);
  localparam int SEED_COL = 6;
  localparam int SEED_ROW = 9;
  typedef enum logic [1:0] {IDLE, CLEAR, SEED} state_e;
  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [COLS-1:0] map_q [ROWS];
  logic [COLS-1:0] map_d [ROWS];
  logic tunnel_q, tunnel_d;
  // Offsets are 13-bit two's complement, so a negative offset compares above the span and is off-board.
  logic [12:0] pl_x, pl_y, px_x, px_y;
  logic pl_on, px_on, upd;
  logic [CW-1:0] pl_col, px_col;
  logic [RW-1:0] pl_row, px_row;
  assign pl_x = {{2{topLeftX[10]}}, topLeftX} + 13'd16 - {2'b00, board_position_X};
  assign pl_y = {{2{topLeftY[10]}}, topLeftY} + 13'd16 - {2'b00, board_position_Y};
  assign px_x = {2'b00, pixelX} - {2'b00, board_position_X};
  assign px_y = {2'b00, pixelY} - {2'b00, board_position_Y};
  assign pl_on = (pl_x < XSPAN) && (pl_y < YSPAN);
  assign px_on = (px_x < XSPAN) && (px_y < YSPAN);
  assign pl_col = CW'(pl_x >> 5);
  assign pl_row = RW'(pl_y >> 5);
  assign px_col = CW'(px_x >> 5);
  assign px_row = RW'(px_y >> 5);
  assign busy = state_q != IDLE;
  assign upd = state_q == IDLE && !clearMap && startOfFrame && player_awake && pl_on;
  assign tunnel_d = !busy && px_on && map_q[px_row][px_col];
  assign tunnelDR = tunnel_q;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    map_d = map_q;
    if (clearMap) begin
      state_d = CLEAR;
      row_d = '0;
    end else begin
      case (state_q)
        IDLE: if (upd) map_d[pl_row][pl_col] = 1'b1;
        CLEAR: begin
          map_d[row_q] = '0;
          row_d = row_q + 1'b1;
          state_d = (row_q == RW'(ROWS - 1)) ? SEED : CLEAR;
        end
        SEED: begin
          map_d[SEED_ROW][SEED_COL] = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      row_q <= '0;
      tunnel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      tunnel_q <= tunnel_d;
      map_q <= map_d;
    end
  end
`ifdef TUNNEL_COUNT_EN
  localparam logic [7:0] MAXC = 8'(COLS * ROWS);
  logic [7:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (state_q == SEED && !clearMap) cnt_q <= 8'd1;
    else if (upd && !map_q[pl_row][pl_col] && cnt_q != MAXC) cnt_q <= cnt_q + 8'd1;
  end
  assign dugCount = cnt_q;
`else
  assign dugCount = 8'd0;
`endif
endmodule
